store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle datapath's load/store path and the word-wide data memory (async read, sync write, 32-bit word port).
- Accepts byte/half/word stores into a small FIFO, then drains them one per cycle as read-modify-write merges into the memory word.
- Serves loads straight from memory; stalls any load that targets a word still pending in the buffer.

Parameters:
- DEPTH, 4, number of buffered store entries; power of two, at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- cpu_mem_read  in  1  load request this cycle
- cpu_mem_write  in  1  store request this cycle; never asserted together with cpu_mem_read
- cpu_addr  in  32  byte address of the access
- cpu_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- cpu_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal
- cpu_rdata  out  32  raw memory word for loads; the datapath does lane select and extension
- stall  out  1  hold the current instruction; request is not taken this cycle
- empty  out  1  no pending entries
- dmem_addr  out  32  to memory address port
- dmem_we  out  1  to memory write enable
- dmem_wdata  out  32  to memory write data
- dmem_rdata  in  32  from memory async read data

Behaviour:
- Entry fields: word index addr[31:2] (30 bits), data (32 bits), byte enable be (4 bits). Storage is a circular FIFO with head, tail and count registers.
- Lane mapping is little-endian: byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Byte store: be = one-hot on addr[1:0].
  - Half store: be = 0011 or 1100, selected by addr[1]; addr[0] is ignored.
  - Word store: be = 1111; addr[1:0] is ignored.
  - Data is replicated into the selected lanes.
- hit: combinational. Set when any valid entry's word index equals cpu_addr[31:2]. An entry being drained this cycle still counts as a hit.
- full: count == DEPTH at cycle start.
- stall = (cpu_mem_write && full) || (cpu_mem_read && hit). stall is forced 0 during reset.
- Enqueue: when cpu_mem_write && !full, write the entry at tail on the posedge; tail advances.
- Load miss (cpu_mem_read && !hit):
  - dmem_addr = cpu_addr; cpu_rdata = dmem_rdata, combinational and zero-latency.
  - Drain is blocked this cycle.
- Drain: enabled when count > 0 and no load miss is using the port.
  - dmem_addr = {head word, 2'b00}.
  - dmem_wdata = per-lane be ? head data : dmem_rdata.
  - dmem_we = 1; head advances on the posedge.
- Count update: simultaneous enqueue and drain leaves count unchanged. Otherwise count is incremented or decremented.
- Idle (no drain, no load): dmem_we = 0, dmem_addr = cpu_addr, dmem_wdata = 0.
- Latency: a store accepted in cycle N reaches memory at the posedge ending cycle N+1 at the earliest. No write bypass.
- Forward progress:
  - A hit-stalled load never blocks drain.
  - A full-stalled store never blocks drain.
  - Therefore no deadlock.
- Ordering: stores drain strictly in FIFO order. Stores to the same word are not coalesced.
- Reset: head = tail = count = 0 and all pending entries are discarded. dmem_we = 0 and stall = 0 while reset is high. empty = 1 from the first cycle after reset.
- Reset mid-drain: the write in the reset cycle is suppressed.
- Illegal input (cpu_size = 11, or read and write together): simulation assertion fires; the access is treated as a word access / as a load.

Decomposition:
- Shared package mem_pkg holds:
  - mem_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - sb_entry_t struct (word, data, be)
  - be_gen and lane-replicate functions
  - DEPTH default
- One combinational sub-module, store_merge: inputs old word, new data and be; output merged word. It is reused by later sub-word load/store work.

Test Plan:
- Reset, then sw 0xDEADBEEF @0x10 in cycle 0: empty=0 in cycle 1; in cycle 1 dmem_we=1, dmem_addr=0x10, dmem_wdata=0xDEADBEEF; empty=1 in cycle 2.
- Memory word @0x20 = 0x11223344:
  - sb 0xAB @0x23 writes 0xAB223344.
  - Then sh 0xBEEF @0x22 writes 0xBEEF3344.
- DEPTH=1, sw @0x0 then sw @0x4 back-to-back: second store sees stall=1 for exactly one cycle (drain of the first), is enqueued in cycle 2, and is written in cycle 3.
- sw 0x55 @0x40 in cycle 0, lw @0x40 in cycle 1: stall=1 in cycle 1 with the drain write; cycle 2 has stall=0 and cpu_rdata=0x00000055.
- sw @0x40 in cycle 0, lw miss @0x80 in cycle 1: dmem_we=0 and dmem_addr=0x80 in cycle 1; the drain to 0x40 occurs in cycle 2.
- sw @0x60 in cycle 0 with reset high in cycle 1: no dmem_we pulse ever occurs for 0x60; empty=1 and stall=0 in cycle 2.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path.
// Provides the access-size encoding, the store-buffer entry layout, the default buffer
// depth, and helpers that turn a right-justified store into byte enables and lane data.
package mem_pkg;

  localparam int unsigned SB_DEPTH = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic [29:0] word;  // addr[31:2]
    logic [31:0] data;  // already replicated into the enabled lanes
    logic [3:0]  be;
  } sb_entry_t;

  // Little-endian byte enables; the illegal size 11 falls back to a word access.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Copies the right-justified store data into every lane it could land in.
  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{data[7:0]}};
      SZ_HALF: rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Byte-lane merge of new store data into an existing memory word.
// Ports:
//   old_word  existing memory word
//   new_data  lane-aligned store data
//   be        byte enables, bit i selects new_data lane i
//   merged    resulting word
module store_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the load/store path and a word-wide data memory
// (async read, sync write). Stores are queued in a small FIFO and drained one per cycle
// as read-modify-write merges; loads go straight to memory unless their word is pending.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_mem_read / cpu_mem_write    load / store request
//   cpu_addr, cpu_wdata, cpu_size   byte address, right-justified data, access size
//   cpu_rdata                       raw memory word returned to loads
//   stall                           request not taken this cycle
//   empty                           no pending stores
//   dmem_addr/we/wdata, dmem_rdata  memory port
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        empty,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LastIdx = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  sb_entry_t        entries_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;

  logic      write_req, hit, full, load_miss, drain, enq;
  sb_entry_t head_entry;
  logic [31:0] merged;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  // A simultaneous read and write is treated as a load.
  assign write_req = cpu_mem_write && !cpu_mem_read;
  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign head_entry = entries_q[head_q];

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (entries_q[i].word == cpu_addr[31:2])) hit = 1'b1;
    end
  end

  assign load_miss = cpu_mem_read && !hit;
  // Stalled loads (hit) and stalled stores (full) leave the port free, so drain proceeds.
  assign drain     = (count_q != '0) && !load_miss;
  assign enq       = write_req && !full;
  assign stall     = !reset && ((write_req && full) || (cpu_mem_read && hit));

  store_merge u_merge (
    .old_word (dmem_rdata),
    .new_data (head_entry.data),
    .be       (head_entry.be),
    .merged   (merged)
  );

  always_comb begin
    dmem_addr  = cpu_addr;
    dmem_we    = 1'b0;
    dmem_wdata = '0;
    cpu_rdata  = '0;
    if (load_miss) begin
      cpu_rdata = dmem_rdata;
    end else if (drain) begin
      dmem_addr  = {head_entry.word, 2'b00};
      dmem_wdata = merged;
      dmem_we    = !reset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // enq and drain never hit the same slot: enq needs !full, drain needs count > 0.
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ptr_inc(tail_q);
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      case ({enq, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      entries_q[tail_q].word <= cpu_addr[31:2];
      entries_q[tail_q].data <= lane_rep(cpu_size, cpu_wdata);
      entries_q[tail_q].be   <= be_gen(cpu_size, cpu_addr[1:0]);
    end
  end

  a_size_legal: assert property (@(posedge clk) disable iff (reset)
    (cpu_mem_read || cpu_mem_write) |-> (cpu_size != 2'b11));

  a_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(cpu_mem_read && cpu_mem_write));

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rd, wr, stall, empty, dwe, mem_init;
  logic [31:0] addr, wdata, rdata, daddr, dwdata, drdata;
  logic [1:0]  size;
  logic [31:0] mem [64];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_mem_read  (rd),
    .cpu_mem_write (wr),
    .cpu_addr      (addr),
    .cpu_wdata     (wdata),
    .cpu_size      (size),
    .cpu_rdata     (rdata),
    .stall         (stall),
    .empty         (empty),
    .dmem_addr     (daddr),
    .dmem_we       (dwe),
    .dmem_wdata    (dwdata),
    .dmem_rdata    (drdata)
  );

  // Second instance for the single-entry case.
  logic        b_reset, b_rd, b_wr, b_stall, b_empty, b_dwe;
  logic [31:0] b_addr, b_wdata, b_rdata, b_daddr, b_dwdata, b_drdata;
  logic [1:0]  b_size;

  store_buffer #(.DEPTH(1)) dut1 (
    .clk           (clk),
    .reset         (b_reset),
    .cpu_mem_read  (b_rd),
    .cpu_mem_write (b_wr),
    .cpu_addr      (b_addr),
    .cpu_wdata     (b_wdata),
    .cpu_size      (b_size),
    .cpu_rdata     (b_rdata),
    .stall         (b_stall),
    .empty         (b_empty),
    .dmem_addr     (b_daddr),
    .dmem_we       (b_dwe),
    .dmem_wdata    (b_dwdata),
    .dmem_rdata    (b_drdata)
  );
  assign b_drdata = 32'h0;

  function automatic logic [31:0] init_val(input int i);
    if (i == 8) return 32'h1122_3344;
    return 32'h5000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Memory environment: async read, sync write.
  assign drdata = mem[daddr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (dwe) begin
      mem[daddr[7:2]] <= dwdata;
    end
  end

  // Reference model: FIFO of pending stores plus committed memory image.
  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  st_t         q[$];
  logic [31:0] ref_mem [64];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Store of 2**s bytes, aligned down to its natural boundary, data right-justified.
  function automatic st_t mk_entry(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] s);
    st_t e;
    int  n, lo;
    n = 1 << s;
    lo = int'(a[1:0]) / n * n;
    e.w = a[31:2];
    e.d = '0;
    e.be = '0;
    for (int b = 0; b < 4; b++) begin
      if (b >= lo && b < lo + n) begin
        e.be[b] = 1'b1;
        e.d[8*b +: 8] = d[8*(b-lo) +: 8];
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] merge_ref(input logic [31:0] old, input st_t e);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (e.be[b]) r[8*b +: 8] = e.d[8*b +: 8];
    return r;
  endfunction

  task automatic cycle(input logic r_rst, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    logic m_hit, m_full, m_lmiss, m_drain;
    reset = r_rst; rd = r; wr = w; addr = a; wdata = d; size = s;
    m_hit = 1'b0;
    foreach (q[i]) if (q[i].w == a[31:2]) m_hit = 1'b1;
    m_full  = (q.size() == DEPTH);
    m_lmiss = r && !m_hit;
    m_drain = (q.size() != 0) && !m_lmiss;
    @(negedge clk);
    if (r_rst) begin
      check("stall_rst", 32'(stall), 32'd0);
      check("we_rst", 32'(dwe), 32'd0);
    end else begin
      check("stall", 32'(stall), 32'((w && m_full) || (r && m_hit)));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("we", 32'(dwe), 32'(m_drain));
      if (m_drain) begin
        check("waddr", daddr, {q[0].w, 2'b00});
        check("wdata", dwdata, merge_ref(ref_mem[q[0].w[5:0]], q[0]));
      end else if (m_lmiss) begin
        check("raddr", daddr, a);
        check("rdata", rdata, ref_mem[a[7:2]]);
      end
    end
    @(posedge clk);
    if (r_rst) begin
      q.delete();
    end else begin
      if (m_drain) begin
        ref_mem[q[0].w[5:0]] = merge_ref(ref_mem[q[0].w[5:0]], q[0]);
        void'(q.pop_front());
      end
      if (w && !m_full) q.push_back(mk_entry(a, d, s));
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
  endtask

  initial begin
    logic [31:0] ra, rdv;
    int op;
    b_reset = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_size = 2'b10;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    mem_init = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    mem_init = 1'b0;

    // Single word store: enqueue, drain next cycle, empty after.
    cycle(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10);
    idle();
    idle();
    check("t1_mem", mem[4], 32'hDEAD_BEEF);

    // Byte then half merges into 0x11223344.
    cycle(1'b0, 1'b0, 1'b1, 32'h23, 32'h0000_00AB, 2'b00);
    idle();
    check("t2_sb", mem[8], 32'hAB22_3344);
    cycle(1'b0, 1'b0, 1'b1, 32'h22, 32'h0000_BEEF, 2'b01);
    idle();
    check("t2_sh", mem[8], 32'hBEEF_3344);

    // Load hitting a pending store stalls, then reads the drained value.
    cycle(1'b0, 1'b0, 1'b1, 32'h40, 32'h0000_0055, 2'b10);
    cycle(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
    cycle(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
    check("t4_mem", mem[16], 32'h0000_0055);

    // Load miss takes the port and defers the drain.
    cycle(1'b0, 1'b0, 1'b1, 32'h40, 32'h0000_1234, 2'b10);
    cycle(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 2'b10);
    idle();
    idle();

    // Reset while a store is pending discards it.
    cycle(1'b0, 1'b0, 1'b1, 32'h60, 32'h0000_CAFE, 2'b10);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    idle();
    check("t6_mem", mem[24], init_val(24));

    // Random traffic over a small address window to provoke hits and full stalls.
    for (int n = 0; n < 600; n++) begin
      op  = int'($urandom_range(0, 9));
      ra  = {26'h0, 6'($urandom_range(0, 63))};
      rdv = $urandom;
      if ($urandom_range(0, 99) == 0) cycle(1'b1, 1'b0, 1'b0, ra, rdv, 2'b10);
      else if (op < 3) cycle(1'b0, 1'b1, 1'b0, ra, rdv, 2'b10);
      else if (op < 8) cycle(1'b0, 1'b0, 1'b1, ra, rdv, 2'($urandom_range(0, 2)));
      else idle();
    end
    for (int n = 0; n < 8; n++) idle();
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    // DEPTH=1: back-to-back stores, second stalls for one cycle.
    @(posedge clk); #1;
    b_reset = 1'b0; b_wr = 1'b1; b_addr = 32'h0; b_wdata = 32'h1;
    @(negedge clk);
    check("d1_c0_stall", 32'(b_stall), 32'd0);
    @(posedge clk); #1;
    b_addr = 32'h4; b_wdata = 32'h2;
    @(negedge clk);
    check("d1_c1_stall", 32'(b_stall), 32'd1);
    check("d1_c1_we", 32'(b_dwe), 32'd1);
    check("d1_c1_addr", b_daddr, 32'h0);
    check("d1_c1_wdata", b_dwdata, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("d1_c2_stall", 32'(b_stall), 32'd0);
    check("d1_c2_we", 32'(b_dwe), 32'd0);
    @(posedge clk); #1;
    b_wr = 1'b0;
    @(negedge clk);
    check("d1_c3_we", 32'(b_dwe), 32'd1);
    check("d1_c3_addr", b_daddr, 32'h4);
    check("d1_c3_wdata", b_dwdata, 32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    check("d1_c4_empty", 32'(b_empty), 32'd1);
    check("d1_c4_we", 32'(b_dwe), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
